// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent rising-edge SR flip-flops with asynchronous active-high reset.
// Each bit's S=R=1 policy is selected by INVALID_MODE, and that condition is also flagged as a registered output.
module sr_flip_flop #(
  parameter int unsigned WIDTH        = 1,
  parameter logic        RESET_VAL    = 1'b0,
  parameter int unsigned INVALID_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] invalid
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'd0,
    MODE_SET    = 2'd1,
    MODE_RESET  = 2'd2,
    MODE_TOGGLE = 2'd3
  } invalid_mode_e;

  localparam invalid_mode_e MODE    = invalid_mode_e'(INVALID_MODE[1:0]);
  localparam logic [WIDTH-1:0] RST_VEC = {WIDTH{RESET_VAL}};

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_invalid;

  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_hold;
  logic [WIDTH-1:0] w_both;
  logic [WIDTH-1:0] w_both_val;
  logic [WIDTH-1:0] w_q_next;

  assign w_set  =  S & ~R;
  assign w_clr  = ~S &  R;
  assign w_hold = ~S & ~R;
  assign w_both =  S &  R;

  // Value taken by a bit whose S and R are both asserted.
  always_comb begin
    // NOTE: default first so every path assigns w_both_val and no latch is inferred.
    w_both_val = r_q;
    case (MODE)
      MODE_HOLD:   w_both_val = r_q;
      MODE_SET:    w_both_val = '1;
      MODE_RESET:  w_both_val = '0;
      MODE_TOGGLE: w_both_val = ~r_q;
      default:     w_both_val = r_q;
    endcase
  end

  // Cleared bits contribute nothing, so they fall out of the OR.
  assign w_q_next = w_set | (w_hold & r_q) | (w_both & w_both_val);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= RST_VEC;
      r_invalid <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_q       <= w_q_next;
      r_invalid <= w_both;
    end
  end

  assign Q       = r_q;
  assign Qn      = ~r_q;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Scoreboard bench for sr_flip_flop: four 4-bit instances, one per INVALID_MODE, share the same stimulus.
// Expected states are pushed when stimulus is driven and popped after the following rising edge.
module tb_sr_flip_flop;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  s_in;
  logic [3:0]  r_in;
  logic [15:0] q_all;
  logic [15:0] qn_all;
  logic [15:0] inv_all;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [15:0] q;
    logic [15:0] inv;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] m_q[4];
  logic [3:0] m_inv[4];

  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b0), .INVALID_MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .S(s_in), .R(r_in),
    .Q(q_all[3:0]), .Qn(qn_all[3:0]), .invalid(inv_all[3:0]));
  sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b0), .INVALID_MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .S(s_in), .R(r_in),
    .Q(q_all[7:4]), .Qn(qn_all[7:4]), .invalid(inv_all[7:4]));
  sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b1), .INVALID_MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .S(s_in), .R(r_in),
    .Q(q_all[11:8]), .Qn(qn_all[11:8]), .invalid(inv_all[11:8]));
  sr_flip_flop #(.WIDTH(4), .RESET_VAL(1'b0), .INVALID_MODE(3)) u_dut3 (
    .clk(clk), .reset(reset), .S(s_in), .R(r_in),
    .Q(q_all[15:12]), .Qn(qn_all[15:12]), .invalid(inv_all[15:12]));

  function automatic logic [3:0] reset_val(input int k);
    return (k == 2) ? 4'hF : 4'h0;
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_q[k]   = reset_val(k);
      m_inv[k] = 4'h0;
    end
  endtask

  // Per-bit truth table; instance k uses INVALID_MODE k.
  task automatic model_edge(input logic [3:0] s, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      for (int b = 0; b < 4; b++) begin
        m_inv[k][b] = s[b] & r[b];
        if (s[b] && r[b]) begin
          if (k == 1)      m_q[k][b] = 1'b1;
          else if (k == 2) m_q[k][b] = 1'b0;
          else if (k == 3) m_q[k][b] = ~m_q[k][b];
        end else if (s[b]) begin
          m_q[k][b] = 1'b1;
        end else if (r[b]) begin
          m_q[k][b] = 1'b0;
        end
      end
    end
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.q   = {m_q[3], m_q[2], m_q[1], m_q[0]};
    e.inv = {m_inv[3], m_inv[2], m_inv[1], m_inv[0]};
    return e;
  endfunction

  task automatic check_now(input string tag);
    exp_t e;
    e = snap();
    check({tag, "_q"},   q_all,   e.q);
    check({tag, "_qn"},  qn_all,  ~e.q);
    check({tag, "_inv"}, inv_all, e.inv);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"},   q_all,   e.q);
      check({tag, "_qn"},  qn_all,  ~e.q);
      check({tag, "_inv"}, inv_all, e.inv);
    end
  endtask

  // Drive on the falling edge, predict, then compare 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic [3:0] s, input logic [3:0] r, input string tag);
    @(negedge clk);
    reset = rst;
    s_in  = s;
    r_in  = r;
    if (rst) model_reset();
    else     model_edge(s, r);
    sb.push_back(snap());
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  initial begin
    reset = 1'b1;
    s_in  = 4'hF;
    r_in  = 4'h0;
    model_reset();
    #1;
    check_now("reset_async_start");

    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'h0, "reset_held");

    step(1'b0, 4'hF, 4'h0, "set");
    step(1'b0, 4'h0, 4'h0, "set_hold");
    step(1'b0, 4'h0, 4'hF, "clear");
    step(1'b0, 4'h0, 4'h0, "clear_hold");
    step(1'b0, 4'hF, 4'h0, "preset");
    step(1'b0, 4'hF, 4'hF, "invalid1");
    step(1'b0, 4'hF, 4'hF, "invalid2");
    step(1'b0, 4'h0, 4'h0, "invalid_drop");
    step(1'b0, 4'b1010, 4'b0110, "mixed_bits");
    step(1'b0, 4'b0101, 4'b0011, "mixed_bits2");
    step(1'b0, 4'h0, 4'hF, "clear_all");

    // Mid-cycle S change must not reach Q before the next rising edge.
    #2;
    s_in = 4'hF;
    r_in = 4'h0;
    #1;
    check_now("edge_no_early");
    model_edge(4'hF, 4'h0);
    sb.push_back(snap());
    @(posedge clk);
    #1;
    compare("edge_update");

    // Asynchronous assertion between edges clears state immediately.
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_now("reset_async_mid");
    step(1'b1, 4'hF, 4'h0, "reset_ignore_s");
    step(1'b1, 4'hF, 4'hF, "reset_ignore_sr");
    step(1'b0, 4'hF, 4'h0, "post_reset_set");

    for (int i = 0; i < 40; i++) begin
      step(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom), "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
